data_split: RTL and testbench
=============================

// Module: data_split
// PURPOSE
//   Width splitter: accepts DIN_W-bit words, emits them as DOUT_W-bit symbols, MSB symbol first.
//   Counterpart of the 2-bit->8-bit consolidation path; its symbol stream re-consolidates to the original word.
//   Sits between the 8-bit word source and the narrow 2-bit link.
//   Has a 1-word pending buffer, so a new word can be accepted while the current word is shifting out.
// PARAMETERS
//   DIN_W   8  input word width; must be an integer multiple of DOUT_W
//   DOUT_W  2  output symbol width
//   RATIO   DIN_W/DOUT_W (localparam, 4 by default)  symbols per word
// PORTS
//   clk      in   1       clock, all logic on rising edge
//   rst      in   1       synchronous reset, active-high
//   din      in   DIN_W   input word
//   din_en   in   1       din valid; a word is accepted on an edge where din_en & din_rdy
//   din_rdy  out  1       block can take a word this cycle (combinational: !pend_vld)
//   dout     out  DOUT_W  output symbol (registered)
//   dout_en  out  1       dout valid this cycle (registered)
//   dout_last out 1       last symbol of a word (only with DATA_SPLIT_LAST_EN)
// BEHAVIOUR
//   Reset (rst=1 at an edge): state=IDLE, dout=0, dout_en=0, cnt=0, sreg=0, pend_vld=0, dout_last=0.
//     Reset mid-word drops the current word and any pending word. No partial symbols appear after reset.
//   FSM states: IDLE (no word in flight) and SHIFT (symbols of the current word being emitted).
//   IDLE, accept at edge k:
//     dout<=din[DIN_W-1 -: DOUT_W], dout_en<=1, sreg<=remaining low bits, cnt<=1, state->SHIFT.
//     First symbol is valid in cycle k+1, so latency is 1 cycle.
//   IDLE, no accept: dout_en<=0; dout holds its last value.
//   SHIFT, cnt<RATIO: dout<=next symbol from top of sreg, sreg shifts left by DOUT_W, cnt<=cnt+1.
//   SHIFT, cnt==RATIO (last symbol currently on dout): next word source, highest priority first:
//     1. pend_vld: load from pend, pend_vld<=0.
//     2. Else accept this edge: load from din.
//     3. Else: dout_en<=0, cnt<=0, state->IDLE.
//     A load emits its first symbol the next cycle. Back-to-back words therefore have no bubble.
//   SHIFT, accept while not at the last symbol: pend<=din, pend_vld<=1, so din_rdy drops next cycle.
//   Simultaneous accept and drain from pend at the last symbol: impossible, because din_rdy=0 while pend_vld=1.
//   Sustained throughput is 1 word per RATIO cycles. din_rdy throttles the source; no word is ever lost or duplicated.
//   din is ignored when din_en=0 or din_rdy=0. No input word is held by the source after acceptance.
//   cnt width: $clog2(RATIO)+1. cnt never exceeds RATIO.
// CONFIGURATION
//   DATA_SPLIT_LAST_EN defined:
//     Adds output dout_last, registered, =1 on the cycle dout carries the final (LSB) symbol of a word, else 0.
//     Reset value 0.
//   Not defined: port dout_last is absent. All other behaviour is identical.
// STRUCTURE
//   Shared package data_width_pkg holds:
//     SYM_W=2, WORD_W=8, SYM_PER_WORD=WORD_W/SYM_W.
//     The state enum type {IDLE, SHIFT}.
//     These are also used by the consolidation block.
//   One sub-module, data_split_pend: 1-entry holding register (pend, pend_vld) with load/drain strobes.
//   FSM, counter and shifter stay in data_split.
// TESTING
//   Single word: din=8'hB4, din_en pulsed 1 cycle from idle.
//     Response: dout_en high for exactly 4 cycles starting the next cycle, dout=2,3,1,0, then IDLE.
//   Back-to-back: din_en held high with 8'hB4 then 8'h1B.
//     Response: 8 contiguous symbols 2,3,1,0,0,1,2,3.
//     din_rdy drops while pending is full; no gap between words.
//   Loopback: feed 16 random words; drive dout/dout_en into the 2->8 consolidation block.
//     Response: reassembled words equal the inputs, in order.
//   Reset mid-word: assert rst after the 2nd symbol of 8'hFF with a word pending.
//     Response: next cycle dout_en=0, din_rdy=1; no further symbols until a new accept.
//   Backpressure: din_en held high while din_rdy=0 with changing din.
//     Response: only words presented with din_rdy=1 appear on dout.
//   DATA_SPLIT_LAST_EN build: run the back-to-back test.
//     Response: dout_last=1 exactly on the 4th and 8th symbol cycles.

Source files
------------

// File: rtl/data_width_pkg.sv
// ----------------------------------------------------------------------------
// data_width_pkg
//   Widths shared by the 8-bit <-> 2-bit split and consolidation paths,
//   plus the state type used by the splitter FSM.
//   SYM_W        narrow link symbol width
//   WORD_W       word width on the wide side
//   SYM_PER_WORD symbols that make up one word
// ----------------------------------------------------------------------------
package data_width_pkg;

  localparam int SYM_W        = 2;
  localparam int WORD_W       = 8;
  localparam int SYM_PER_WORD = WORD_W / SYM_W;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ds_state_t;

endpackage

// File: rtl/data_split_pend.sv
// ----------------------------------------------------------------------------
// data_split_pend
//   One-entry holding register for the word that arrives while the splitter
//   is still shifting out the previous one.
//   Ports:
//     clk, rst     clock / synchronous active-high reset
//     i_load       capture i_din, mark entry valid
//     i_drain      entry consumed, mark invalid
//     i_din        word to capture
//     o_pend       held word
//     o_pend_vld   entry holds a word
// ----------------------------------------------------------------------------
module data_split_pend #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_drain,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_pend,
  output logic         o_pend_vld
);

  logic [W-1:0] r_pend;
  logic         r_pend_vld;

  // load and drain never coincide: the source is stalled while the entry is
  // full, so load wins only as a defensive ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
    end else if (i_load) begin
      r_pend     <= i_din;
      r_pend_vld <= 1'b1;
    end else if (i_drain) begin
      r_pend_vld <= 1'b0;
    end
  end

  assign o_pend     = r_pend;
  assign o_pend_vld = r_pend_vld;

endmodule

// File: rtl/data_split.sv
// ----------------------------------------------------------------------------
// data_split
//   Width splitter: DIN_W-bit words in, DOUT_W-bit symbols out, MSB symbol
//   first. A one-word pending buffer lets the next word be accepted while the
//   current one shifts out, so back-to-back words leave with no bubble.
//   Ports:
//     clk        clock, rising edge
//     rst        synchronous reset, active-high
//     din        input word
//     din_en     din valid; accepted when din_en & din_rdy
//     din_rdy    can accept a word this cycle (combinational, !pend_vld)
//     dout       output symbol (registered)
//     dout_en    dout valid (registered)
//     dout_last  final symbol of a word (registered, only with
//                DATA_SPLIT_LAST_EN defined)
//   Config macro: DATA_SPLIT_LAST_EN adds the dout_last output.
// ----------------------------------------------------------------------------
module data_split
  import data_width_pkg::*;
#(
  parameter int DIN_W  = WORD_W,
  parameter int DOUT_W = SYM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIN_W-1:0]  din,
  input  logic              din_en,
  output logic              din_rdy,
  output logic [DOUT_W-1:0] dout,
  output logic              dout_en
`ifdef DATA_SPLIT_LAST_EN
  ,
  output logic              dout_last
`endif
);

  localparam int RATIO = DIN_W / DOUT_W;
  localparam int CNT_W = $clog2(RATIO) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ds_state_t         r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DIN_W-1:0]  r_sreg, w_sreg_nxt;
  logic [DOUT_W-1:0] r_dout, w_dout_nxt;
  logic              r_dout_en, w_dout_en_nxt;

  logic              w_accept;
  logic              w_at_last;
  logic              w_ld;
  logic [DIN_W-1:0]  w_ld_word;
  logic              w_pend_load;
  logic              w_pend_drain;
  logic [DIN_W-1:0]  w_pend;
  logic              w_pend_vld;

  assign din_rdy   = !w_pend_vld;
  assign w_accept  = din_en && din_rdy;
  assign w_at_last = (r_cnt == CNT_LAST);

  data_split_pend #(.W(DIN_W)) u_pend (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_pend_load),
    .i_drain    (w_pend_drain),
    .i_din      (din),
    .o_pend     (w_pend),
    .o_pend_vld (w_pend_vld)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_sreg_nxt    = r_sreg;
    w_dout_nxt    = r_dout;
    w_dout_en_nxt = r_dout_en;
    w_pend_load   = 1'b0;
    w_pend_drain  = 1'b0;
    w_ld          = 1'b0;
    w_ld_word     = din;

    case (r_state)
      IDLE: begin
        // pend is always empty here: it only fills mid-word and is emptied
        // at that word's last symbol.
        if (w_accept) w_ld = 1'b1;
        else          w_dout_en_nxt = 1'b0;
      end
      SHIFT: begin
        if (!w_at_last) begin
          w_dout_nxt = r_sreg[DIN_W-1 -: DOUT_W];
          w_sreg_nxt = r_sreg << DOUT_W;
          w_cnt_nxt  = r_cnt + 1'b1;
          if (w_accept) w_pend_load = 1'b1;
        end else if (w_pend_vld) begin
          w_ld         = 1'b1;
          w_ld_word    = w_pend;
          w_pend_drain = 1'b1;
        end else if (w_accept) begin
          w_ld = 1'b1;
        end else begin
          w_dout_en_nxt = 1'b0;
          w_cnt_nxt     = '0;
          w_state_nxt   = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Loading a word puts its MSB symbol straight onto dout; the remaining
    // bits sit left-aligned in sreg.
    if (w_ld) begin
      w_dout_nxt    = w_ld_word[DIN_W-1 -: DOUT_W];
      w_sreg_nxt    = w_ld_word << DOUT_W;
      w_cnt_nxt     = CNT_ONE;
      w_dout_en_nxt = 1'b1;
      w_state_nxt   = SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_sreg    <= '0;
      r_dout    <= '0;
      r_dout_en <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sreg    <= w_sreg_nxt;
      r_dout    <= w_dout_nxt;
      r_dout_en <= w_dout_en_nxt;
    end
  end

  assign dout    = r_dout;
  assign dout_en = r_dout_en;

`ifdef DATA_SPLIT_LAST_EN
  logic r_last;

  // cnt counts the symbol now on dout, so the final one is cnt==RATIO.
  always_ff @(posedge clk) begin
    if (rst) r_last <= 1'b0;
    else     r_last <= w_dout_en_nxt && (w_cnt_nxt == CNT_LAST);
  end

  assign dout_last = r_last;
`endif

endmodule

// File: tb/tb_data_split.sv
module tb_data_split;
  import data_width_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_en;
  logic       din_rdy;
  logic [1:0] dout;
  logic       dout_en;
`ifdef DATA_SPLIT_LAST_EN
  logic       dout_last;
`endif

  always #5 clk = ~clk;

  data_split dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_en    (din_en),
    .din_rdy   (din_rdy),
    .dout      (dout),
    .dout_en   (dout_en)
`ifdef DATA_SPLIT_LAST_EN
    ,
    .dout_last (dout_last)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One table step: inputs applied for one edge, din_rdy expected before the
  // edge, registered outputs expected after it.
  typedef struct {
    logic [7:0] din;
    logic       en;
    logic       rdy;
    logic       oen;
    logic [1:0] od;
    logic       last;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic [7:0] d, input logic e, input logic r,
                     input logic oe, input logic [1:0] od, input logic l);
    vec_t v;
    v.din = d; v.en = e; v.rdy = r; v.oen = oe; v.od = od; v.last = l;
    tv.push_back(v);
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] acc;
  int         nsym;
  int         sent;
  int         rcv;
  int         cyc;
  logic [7:0] w;

  initial begin
    rst = 1'b1; din = '0; din_en = 1'b0;

    // single word B4 -> 2,3,1,0
    add(8'hB4,1,1, 1,2'd2,0);
    add(8'h00,0,1, 1,2'd3,0);
    add(8'h00,0,1, 1,2'd1,0);
    add(8'h00,0,1, 1,2'd0,1);
    add(8'h00,0,1, 0,2'd0,0);
    add(8'h00,0,1, 0,2'd0,0);
    // back-to-back B4,1B -> 2,3,1,0,0,1,2,3 with no gap
    add(8'hB4,1,1, 1,2'd2,0);
    add(8'h1B,1,1, 1,2'd3,0);
    add(8'h1B,1,0, 1,2'd1,0);
    add(8'h00,0,0, 1,2'd0,1);
    add(8'h00,0,0, 1,2'd0,0);
    add(8'h00,0,1, 1,2'd1,0);
    add(8'h00,0,1, 1,2'd2,0);
    add(8'h00,0,1, 1,2'd3,1);
    add(8'h00,0,1, 0,2'd3,0);
    // backpressure: C6 then 39; AA,55,FF,77 offered while full are dropped
    add(8'hC6,1,1, 1,2'd3,0);
    add(8'h39,1,1, 1,2'd0,0);
    add(8'hAA,1,0, 1,2'd1,0);
    add(8'h55,1,0, 1,2'd2,1);
    add(8'hFF,1,0, 1,2'd0,0);
    add(8'h81,1,1, 1,2'd3,0);
    add(8'h77,1,0, 1,2'd2,0);
    add(8'h00,0,0, 1,2'd1,1);
    add(8'h00,0,0, 1,2'd2,0);
    add(8'h00,0,1, 1,2'd0,0);
    add(8'h00,0,1, 1,2'd0,0);
    add(8'h00,0,1, 1,2'd1,1);
    // direct load from din exactly at the last symbol
    add(8'hE4,1,1, 1,2'd3,0);
    add(8'h00,0,1, 1,2'd2,0);
    add(8'h00,0,1, 1,2'd1,0);
    add(8'h00,0,1, 1,2'd0,1);
    add(8'h00,0,1, 0,2'd0,0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout_en", 32'(dout_en), 32'd0);
    chk("rst_dout",    32'(dout),    32'd0);
    chk("rst_din_rdy", 32'(din_rdy), 32'd1);
`ifdef DATA_SPLIT_LAST_EN
    chk("rst_last",    32'(dout_last), 32'd0);
`endif
    @(negedge clk); rst = 1'b0;

    foreach (tv[i]) begin
      din = tv[i].din; din_en = tv[i].en;
      #1 chk($sformatf("v%0d_rdy", i), 32'(din_rdy), 32'(tv[i].rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_en", i), 32'(dout_en), 32'(tv[i].oen));
      if (tv[i].oen || i == tv.size()-1)
        chk($sformatf("v%0d_dout", i), 32'(dout), 32'(tv[i].od));
`ifdef DATA_SPLIT_LAST_EN
      chk($sformatf("v%0d_last", i), 32'(dout_last), 32'(tv[i].last));
`endif
      @(negedge clk);
    end
    din_en = 1'b0;
    repeat (2) @(negedge clk);

    // reset mid-word: FF shifting, 12 pending, reset after 2nd symbol
    din = 8'hFF; din_en = 1'b1;
    @(negedge clk); din = 8'h12;
    @(negedge clk); din_en = 1'b0;
    chk("mid_pend_full", 32'(din_rdy), 32'd0);
    chk("mid_sym2", 32'(dout), 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_en",  32'(dout_en), 32'd0);
    chk("mid_rst_rdy", 32'(din_rdy), 32'd1);
    @(negedge clk); rst = 1'b0;
    nsym = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (dout_en) nsym++;
    end
    chk("mid_no_syms", 32'(nsym), 32'd0);
    // a fresh word gives exactly 4 symbols; the dropped pending word never shows
    @(negedge clk); din = 8'h4E; din_en = 1'b1;
    @(negedge clk); din_en = 1'b0;
    nsym = 0; acc = '0;
    if (dout_en) begin nsym++; acc = {acc[5:0], dout}; end
    repeat (8) begin
      @(posedge clk); #1;
      if (dout_en) begin nsym++; acc = {acc[5:0], dout}; end
    end
    chk("post_rst_syms", 32'(nsym), 32'd4);
    chk("post_rst_word", 32'(acc),  32'h4E);

    // loopback through a behavioural 2->8 consolidator, random source pacing
    @(negedge clk);
    sent = 0; rcv = 0; nsym = 0; acc = '0; cyc = 0;
    while (rcv < 16 && cyc < 2000) begin
      @(negedge clk);
      din_en = (sent < 16) && ($urandom_range(0, 3) != 0);
      din    = 8'($urandom);
      if (din_en && din_rdy) begin
        exp_q.push_back(din);
        sent++;
      end
      @(posedge clk); #1;
      if (dout_en) begin
        acc = {acc[5:0], dout};
        nsym++;
`ifdef DATA_SPLIT_LAST_EN
        chk("lb_last", 32'(dout_last), 32'(nsym == SYM_PER_WORD));
`endif
        if (nsym == SYM_PER_WORD) begin
          nsym = 0;
          w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          chk($sformatf("lb_word%0d", rcv), 32'(acc), 32'(w));
          rcv++;
        end
      end
      cyc++;
    end
    din_en = 1'b0;
    chk("lb_done", 32'(rcv), 32'd16);
    chk("lb_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
